// File: rtl/lc3_pkg.sv
// Shared LC-3b datapath definitions: data width, NZP bit positions and the
// packed condition-code type used by every unit that handles flags.
package lc3_pkg;

    localparam int DATA_W = 16;

    // Bit positions of the flags inside a 3-bit {N,Z,P} vector.
    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;

    // Condition codes. Field order matches the {N,Z,P} bit layout.
    typedef struct packed {
        logic n;
        logic z;
        logic p;
    } nzp_t;

endpackage : lc3_pkg

// File: rtl/cc_classify.sv
// Sign classifier: maps a two's-complement word onto a one-hot {n,z,p}.
// Purely combinational, so any unit needing sign information can reuse it.
module cc_classify
    import lc3_pkg::*;
#(
    parameter int DATA_W = lc3_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] i_data,
    output nzp_t              o_nzp
);

    logic w_neg;
    logic w_zero;

    assign w_neg  = i_data[DATA_W-1];
    assign w_zero = (i_data == '0);

    // Exactly one flag is set for every defined input word.
    always_comb begin
        o_nzp   = '0;
        o_nzp.n = w_neg;
        o_nzp.z = w_zero;
        o_nzp.p = ~w_neg & ~w_zero;
    end

endmodule : cc_classify

// File: rtl/cond_code_reg.sv
// LC-3b condition-code register. Latches the classified ALU/bus result on
// LD_CC, restores a saved {N,Z,P} verbatim on LD_PSR (which has priority),
// and evaluates the branch condition combinationally from the stored flags.
module cond_code_reg
    import lc3_pkg::*;
#(
    parameter int DATA_W = lc3_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              LD_CC,
    input  logic [DATA_W-1:0] data,
    input  logic              LD_PSR,
    input  logic [2:0]        psr_nzp,
    input  logic [2:0]        br_nzp,
    output logic              N,
    output logic              Z,
    output logic              P,
    output logic              br_taken
);

    nzp_t       w_class;
    nzp_t       r_nzp;
    logic [2:0] w_flags;

    cc_classify #(
        .DATA_W (DATA_W)
    ) u_cc_classify (
        .i_data (data),
        .o_nzp  (w_class)
    );

    // Flag register: reset to 000, restore path beats classify path, else hold.
    // Data is only sampled when LD_CC is set, so unknown data cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nzp <= '0;
        end else if (LD_PSR) begin
            r_nzp <= nzp_t'(psr_nzp);
        end else if (LD_CC) begin
            r_nzp <= w_class;
        end
    end

    assign w_flags = r_nzp;

    assign N = w_flags[NZP_N];
    assign Z = w_flags[NZP_Z];
    assign P = w_flags[NZP_P];

    // Branch is taken when any flag selected by the instruction mask is set.
    assign br_taken = |(br_nzp & w_flags);

endmodule : cond_code_reg

// File: tb/tb_cond_code_reg.sv
// Directed bench for cond_code_reg: every expected value is hand-computed.
module tb_cond_code_reg;

    logic        clk;
    logic        rst_n;
    logic        LD_CC;
    logic [15:0] data;
    logic        LD_PSR;
    logic [2:0]  psr_nzp;
    logic [2:0]  br_nzp;
    logic        N;
    logic        Z;
    logic        P;
    logic        br_taken;

    int checks;
    int failures;

    cond_code_reg #(
        .DATA_W (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .LD_CC    (LD_CC),
        .data     (data),
        .LD_PSR   (LD_PSR),
        .psr_nzp  (psr_nzp),
        .br_nzp   (br_nzp),
        .N        (N),
        .Z        (Z),
        .P        (P),
        .br_taken (br_taken)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Compare the registered flags as a 3-bit {N,Z,P}.
    task automatic check_flags(input string tag, input logic [2:0] exp);
        check(tag, {1'b0, N, Z, P}, {1'b0, exp});
    endtask

    task automatic check_br(input string tag, input logic [2:0] mask, input logic exp);
        br_nzp = mask;
        #1;
        check(tag, {3'b000, br_taken}, {3'b000, exp});
    endtask

    // Advance one rising edge and settle 1 unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-edge LD_CC pulse with the given data word.
    task automatic load_cc(input logic [15:0] d);
        data  = d;
        LD_CC = 1'b1;
        tick();
        LD_CC = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        LD_CC    = 1'b0;
        LD_PSR   = 1'b0;
        data     = '0;
        psr_nzp  = '0;
        br_nzp   = '0;

        // Reset state
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        check_flags("reset_flags", 3'b000);
        check_br("reset_br111", 3'b111, 1'b0);

        // Negative value, then hold with changed data
        load_cc(16'hFFFB);
        check_flags("load_neg5", 3'b100);
        data = 16'h0005;
        tick();
        tick();
        check_flags("hold_data5", 3'b100);
        data = 'x;
        tick();
        check_flags("hold_data_x", 3'b100);

        // Sequence of loads including boundaries
        load_cc(16'h0000);
        check_flags("load_zero", 3'b010);
        load_cc(16'h0005);
        check_flags("load_pos5", 3'b001);
        load_cc(16'h8000);
        check_flags("load_8000", 3'b100);
        load_cc(16'h7FFF);
        check_flags("load_7fff", 3'b001);

        // LD_CC held across edges re-latches with current data
        data  = 16'h0000;
        LD_CC = 1'b1;
        tick();
        check_flags("held_edge1_zero", 3'b010);
        data = 16'hFFFF;
        tick();
        check_flags("held_edge2_ffff", 3'b100);
        data = 16'h0000;
        tick();
        LD_CC = 1'b0;
        check_flags("held_edge3_zero", 3'b010);

        // Branch evaluation with flags 010
        check_br("br_010", 3'b010, 1'b1);
        check_br("br_101", 3'b101, 1'b0);
        check_br("br_000", 3'b000, 1'b0);
        check_br("br_111", 3'b111, 1'b1);

        // LD_PSR beats LD_CC on the same edge
        data    = 16'h0005;
        LD_CC   = 1'b1;
        psr_nzp = 3'b100;
        LD_PSR  = 1'b1;
        tick();
        LD_CC  = 1'b0;
        LD_PSR = 1'b0;
        check_flags("psr_priority", 3'b100);

        // LD_PSR alone, no one-hot enforcement
        psr_nzp = 3'b011;
        LD_PSR  = 1'b1;
        tick();
        LD_PSR = 1'b0;
        check_flags("psr_011", 3'b011);
        check_br("br_100_on_011", 3'b100, 1'b0);
        check_br("br_001_on_011", 3'b001, 1'b1);
        check_br("br_000_on_011", 3'b000, 1'b0);

        // Asynchronous reset between edges while a load is pending
        load_cc(16'h0005);
        check_flags("pre_reset_001", 3'b001);
        data  = 16'h8000;
        LD_CC = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_flags("async_reset_now", 3'b000);
        tick();
        check_flags("reset_held_edge", 3'b000);
        check_br("reset_held_br111", 3'b111, 1'b0);
        #2 rst_n = 1'b1;
        data = 16'hFFFF;
        tick();
        LD_CC = 1'b0;
        check_flags("post_reset_load_m1", 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cond_code_reg
